// File: rtl/sm4_ctrl.sv
// SM4 block-cipher sequencer: key expansion, block handshake, round engine start and result handshake.
// Define SM4_CTRL_STAT_EN to add the 32-bit block_count_out result counter.
module sm4_ctrl #(
  parameter int unsigned KEY_TIMEOUT = 48
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sm4_enable_in,
  input  logic key_load_in,
  output logic enable_key_exp_out,
  output logic user_key_valid_out,
  input  logic key_exp_finished_in,
  input  logic data_valid_in,
  output logic data_ready_out,
  input  logic decrypt_in,
  output logic round_start_out,
  output logic round_decrypt_out,
  input  logic round_done_in,
  output logic result_valid_out,
  input  logic result_ready_in,
  output logic key_ready_out,
  output logic key_err_out,
  output logic busy_out
`ifdef SM4_CTRL_STAT_EN
  ,
  output logic [31:0] block_count_out
`endif
);

  // state    | meaning
  // IDLE     | disabled or no valid key
  // KEY_REQ  | one-cycle expander setup before key-valid rises
  // KEY_WAIT | expansion running, timeout down-counter active
  // READY    | key usable, accepting a block
  // CRYPT    | round engine busy on the accepted block
  // RESULT   | result held until downstream takes it
  typedef enum logic [2:0] {
    S_IDLE, S_KEY_REQ, S_KEY_WAIT, S_READY, S_CRYPT, S_RESULT
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       pend, pend_nxt;
  logic       mode_nxt, start_nxt, err_nxt;
  logic       exp_nxt, ukv_nxt, kr_nxt, dr_nxt, rv_nxt, busy_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend;
    mode_nxt  = round_decrypt_out;
    start_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: if (key_load_in) state_nxt = S_KEY_REQ;
      S_KEY_REQ: begin
        state_nxt = S_KEY_WAIT;
        cnt_nxt   = 8'(KEY_TIMEOUT - 1);
      end
      S_KEY_WAIT: begin
        if (key_exp_finished_in) begin
          state_nxt = S_READY;
        end else if (cnt == 8'd0) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_READY: begin
        if (pend || key_load_in) begin
          state_nxt = S_KEY_REQ;
          pend_nxt  = 1'b0;
        end else if (data_valid_in && data_ready_out) begin
          state_nxt = S_CRYPT;
          mode_nxt  = decrypt_in;
          start_nxt = 1'b1;
        end
      end
      S_CRYPT: begin
        if (key_load_in) pend_nxt = 1'b1;
        if (round_done_in) state_nxt = S_RESULT;
      end
      S_RESULT: begin
        if (key_load_in) pend_nxt = 1'b1;
        if (result_valid_out && result_ready_in) state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!sm4_enable_in) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 8'd0;
      pend_nxt  = 1'b0;
      mode_nxt  = 1'b0;
      start_nxt = 1'b0;
      err_nxt   = 1'b0;
    end
    // Outputs are decoded from the next state so they can be registered without lag.
    // Re-keying from READY drops the expander enable for the KEY_REQ cycle.
    exp_nxt  = (state_nxt inside {S_KEY_WAIT, S_READY, S_CRYPT, S_RESULT}) ||
               (state_nxt == S_KEY_REQ && state == S_IDLE);
    ukv_nxt  = (state_nxt == S_KEY_WAIT);
    kr_nxt   = (state_nxt inside {S_READY, S_CRYPT, S_RESULT});
    dr_nxt   = (state_nxt == S_READY) && !key_load_in && !pend_nxt;
    rv_nxt   = (state_nxt == S_RESULT);
    busy_nxt = !(state_nxt inside {S_IDLE, S_READY});
    if (!(state_nxt inside {S_CRYPT, S_RESULT})) mode_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      cnt                <= 8'd0;
      pend               <= 1'b0;
      enable_key_exp_out <= 1'b0;
      user_key_valid_out <= 1'b0;
      data_ready_out     <= 1'b0;
      round_start_out    <= 1'b0;
      round_decrypt_out  <= 1'b0;
      result_valid_out   <= 1'b0;
      key_ready_out      <= 1'b0;
      key_err_out        <= 1'b0;
      busy_out           <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      pend               <= pend_nxt;
      enable_key_exp_out <= exp_nxt;
      user_key_valid_out <= ukv_nxt;
      data_ready_out     <= dr_nxt;
      round_start_out    <= start_nxt;
      round_decrypt_out  <= mode_nxt;
      result_valid_out   <= rv_nxt;
      key_ready_out      <= kr_nxt;
      key_err_out        <= err_nxt;
      busy_out           <= busy_nxt;
    end
  end

`ifdef SM4_CTRL_STAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_count_out <= 32'd0;
    end else if (state == S_RESULT && result_valid_out && result_ready_in) begin
      block_count_out <= block_count_out + 32'd1;
    end
  end
`endif

endmodule
